// File: rtl/param_delay_chain.sv
// param_delay_chain: multi-lane shift-register delay line.
//   Per-stage valid tracking, runtime tap mux, occupancy count.
//   Optional per-lane even-parity storage and checking when the macro
//   DELAY_CHAIN_PARITY_EN is defined. This adds the ports inj_err and parity_err.
//   Per-lane data path lives in param_delay_chain_lane. Shared valid/count
//   control lives in the top.

module param_delay_chain_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int TW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic [TW-1:0]    tap_sel,
`ifdef DELAY_CHAIN_PARITY_EN
  input  logic             inj_err,
  input  logic             dout_valid,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] tap_out
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic                        tap_in_range;

  // next stage data: clear beats shift, shift beats hold
  always_comb begin
    stage_d = stage_q;
    if (clear) begin
      stage_d = '0;
    end else if (shift_en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // stage data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

  // tap mux; out-of-range selects read as zero (widened compare keeps it valid for any DEPTH)
  always_comb begin
    tap_in_range = 32'(tap_sel) < 32'(DEPTH);
    tap_out      = '0;
    if (tap_in_range) tap_out = stage_q[tap_sel];
  end

`ifdef DELAY_CHAIN_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             par_err_q, par_err_d;

  // parity travels alongside the data; inj_err corrupts it on entry
  always_comb begin
    par_d = par_q;
    if (clear) begin
      par_d = '0;
    end else if (shift_en) begin
      par_d[0] = (^din) ^ inj_err;
      for (int i = 1; i < DEPTH; i++) par_d[i] = par_q[i-1];
    end
  end

  // sticky error, only raised by a valid output word, dropped by clear
  always_comb begin
    par_err_d = par_err_q;
    if (clear) par_err_d = 1'b0;
    else if (dout_valid && ((^stage_q[DEPTH-1]) != par_q[DEPTH-1])) par_err_d = 1'b1;
  end

  // parity registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

module param_delay_chain #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 10,
  parameter int  LANES = 2,
  localparam int TW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   clear,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   din_valid,
  input  logic [TW-1:0]          tap_sel,
`ifdef DELAY_CHAIN_PARITY_EN
  input  logic                   inj_err,
  output logic [LANES-1:0]       parity_err,
`endif
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic [LANES*WIDTH-1:0] tap_out,
  output logic                   tap_valid,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;

  // valid shift register and incremental occupancy count
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    fill_cnt_d = fill_cnt_q;
    if (clear) begin
      vld_pipe_d = '0;
      fill_cnt_d = '0;
    end else if (shift_en) begin
      vld_pipe_d = {vld_pipe_q[DEPTH-2:0], din_valid};
      if (din_valid && !vld_pipe_q[DEPTH-1])      fill_cnt_d = fill_cnt_q + CW'(1);
      else if (!din_valid && vld_pipe_q[DEPTH-1]) fill_cnt_d = fill_cnt_q - CW'(1);
    end
  end

  // valid/count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      fill_cnt_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // tap valid mux, zero when out of range
  always_comb begin
    tap_valid = 1'b0;
    if (32'(tap_sel) < 32'(DEPTH)) tap_valid = vld_pipe_q[tap_sel];
  end

  assign dout_valid = vld_pipe_q[DEPTH-1];
  assign fill_cnt   = fill_cnt_q;
  assign full       = (fill_cnt_q == CW'(DEPTH));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    param_delay_chain_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TW(TW)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .shift_en   (shift_en),
      .clear      (clear),
      .din        (din[l*WIDTH +: WIDTH]),
      .tap_sel    (tap_sel),
`ifdef DELAY_CHAIN_PARITY_EN
      .inj_err    (inj_err),
      .dout_valid (vld_pipe_q[DEPTH-1]),
      .par_err    (parity_err[l]),
`endif
      .dout       (dout[l*WIDTH +: WIDTH]),
      .tap_out    (tap_out[l*WIDTH +: WIDTH])
    );
  end

endmodule
